// File: rtl/seq_alu_if.sv
// seq_alu_if
//   Groups the request and response signals of the sequential ALU.
//   master : requester side (register file / control) drives START,
//            ALUOP, DATA_A, DATA_B, carry_in and observes the results.
//   slave  : the ALU itself, consuming the request and driving RESULT,
//            RESULT_HI, carry_out, ZERO, OVERFLOW, ILLEGAL, BUSY, DONE.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [3:0]       ALUOP;
  logic [WIDTH-1:0] DATA_A;
  logic [WIDTH-1:0] DATA_B;
  logic             carry_in;
  logic [WIDTH-1:0] RESULT;
  logic [WIDTH-1:0] RESULT_HI;
  logic             carry_out;
  logic             ZERO;
  logic             OVERFLOW;
  logic             ILLEGAL;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, ALUOP, DATA_A, DATA_B, carry_in,
    input  RESULT, RESULT_HI, carry_out, ZERO, OVERFLOW, ILLEGAL, BUSY, DONE
  );

  modport slave (
    input  START, ALUOP, DATA_A, DATA_B, carry_in,
    output RESULT, RESULT_HI, carry_out, ZERO, OVERFLOW, ILLEGAL, BUSY, DONE
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu
//   Clocked, width-parametrised ALU. A request is taken on START while not
//   BUSY; single-cycle ops finish on the same edge, MUL runs as an
//   LSB-first shift-add over WIDTH cycles producing a 2*WIDTH product.
//   Results and flags are registered and held until the next completion.
// Ports
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : seq_alu_if slave modport (request in, results/flags/handshake out)
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic    CLK,
  input logic    RST,
  seq_alu_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADDC = 4'b0100;
  localparam logic [3:0] OP_SUBC = 4'b0101;
  localparam logic [3:0] OP_CMP  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Arithmetic is done one bit wider than the operands so bit WIDTH is the
  // carry (add) or borrow (subtract) out.
  logic [WIDTH:0] ext_a, ext_b, ext_cin, ext_nbor;
  logic [WIDTH:0] sum, sum_c, diff, diff_c;
  logic           a_msb, b_msb;

  assign ext_a    = {1'b0, bus.DATA_A};
  assign ext_b    = {1'b0, bus.DATA_B};
  assign ext_cin  = {{WIDTH{1'b0}}, bus.carry_in};
  assign ext_nbor = {{WIDTH{1'b0}}, ~bus.carry_in};
  assign sum      = ext_a + ext_b;
  assign sum_c    = ext_a + ext_b + ext_cin;
  assign diff     = ext_a - ext_b;
  assign diff_c   = ext_a - ext_b - ext_nbor;
  assign a_msb    = bus.DATA_A[WIDTH-1];
  assign b_msb    = bus.DATA_B[WIDTH-1];

  // Partial product for the current multiplier bit; mplier shifts right so
  // bit 0 is always the one being consumed.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and next-output logic; everything holds unless a request is
  // accepted or the multiplier finishes.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          done_d = 1'b1;
          ill_d  = 1'b0;
          hi_d   = '0;
          ovf_d  = 1'b0;
          case (bus.ALUOP)
            OP_AND: result_d = bus.DATA_A & bus.DATA_B;
            OP_OR:  result_d = bus.DATA_A | bus.DATA_B;
            OP_XOR: result_d = bus.DATA_A ^ bus.DATA_B;
            OP_CMP: result_d = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            OP_ADD: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              ovf_d    = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
            end
            OP_ADDC: begin
              result_d = sum_c[WIDTH-1:0];
              carry_d  = sum_c[WIDTH];
              ovf_d    = (a_msb == b_msb) && (sum_c[WIDTH-1] != a_msb);
            end
            OP_SUB: begin
              result_d = diff[WIDTH-1:0];
              carry_d  = ~diff[WIDTH];
              ovf_d    = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
            end
            OP_SUBC: begin
              result_d = diff_c[WIDTH-1:0];
              carry_d  = ~diff_c[WIDTH];
              ovf_d    = (a_msb != b_msb) && (diff_c[WIDTH-1] != a_msb);
            end
            OP_MUL: begin
              done_d   = 1'b0;
              ill_d    = ill_q;
              hi_d     = hi_q;
              ovf_d    = ovf_q;
              mcand_d  = {{WIDTH{1'b0}}, bus.DATA_A};
              mplier_d = bus.DATA_B;
              acc_d    = '0;
              count_d  = '0;
              busy_d   = 1'b1;
              state_d  = MUL_RUN;
            end
            default: begin
              // Undefined opcode: signal it, keep every result and flag.
              ill_d = 1'b1;
              hi_d  = hi_q;
              ovf_d = ovf_q;
            end
          endcase
          if (bus.ALUOP != OP_MUL && bus.ALUOP <= OP_XOR)
            zero_d = (result_d == '0);
        end
      end

      MUL_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          ill_d    = 1'b0;
          ovf_d    = 1'b0;
          result_d = acc_sum[WIDTH-1:0];
          hi_d     = acc_sum[2*WIDTH-1:WIDTH];
          carry_d  = |acc_sum[2*WIDTH-1:WIDTH];
          zero_d   = (acc_sum == '0);
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.RESULT    = result_q;
  assign bus.RESULT_HI = hi_q;
  assign bus.carry_out = carry_q;
  assign bus.ZERO      = zero_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.ILLEGAL   = ill_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
//   Bench for seq_alu at WIDTH=8: directed scenarios followed by random
//   requests, every completion compared against an arithmetic reference
//   model of the ALU's architectural outputs.
// Ports
//   none (top-level bench)
module tb_seq_alu;

  localparam int WIDTH = 8;
  localparam longint MASK = (64'sd1 <<< WIDTH) - 1;
  localparam longint SMAX = (64'sd1 <<< (WIDTH - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (WIDTH - 1));

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the outputs should read right now.
  longint m_res, m_hi;
  bit     m_carry, m_zero, m_ovf, m_ill, m_busy, m_done;

  function automatic longint sx(longint v);
    return (v > SMAX) ? v - (MASK + 1) : v;
  endfunction

  function automatic void model_reset();
    m_res = 0; m_hi = 0; m_carry = 0; m_zero = 1;
    m_ovf = 0; m_ill = 0; m_busy = 0; m_done = 0;
  endfunction

  // Effect of one completed request on the architectural outputs.
  function automatic void model_apply(int op, longint a, longint b, bit cin);
    longint r, sr, p;
    m_done = 1;
    if (op > 8) begin
      m_ill = 1;
      return;
    end
    m_ill = 0;
    m_hi  = 0;
    m_ovf = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      7: r = a ^ b;
      6: r = (a < b) ? 1 : 0;
      2: begin r = a + b;            sr = sx(a) + sx(b);            m_carry = (r > MASK); end
      4: begin r = a + b + cin;      sr = sx(a) + sx(b) + cin;      m_carry = (r > MASK); end
      3: begin r = a - b;            sr = sx(a) - sx(b);            m_carry = (a >= b); end
      5: begin r = a - b - (1 - cin); sr = sx(a) - sx(b) - (1 - cin); m_carry = (a >= b + (1 - cin)); end
      default: begin
        p = a * b;
        r = p;
        m_hi = (p >> WIDTH) & MASK;
        m_carry = (m_hi != 0);
      end
    endcase
    if (op >= 2 && op <= 5) m_ovf = (sr > SMAX) || (sr < SMIN);
    m_res  = r & MASK;
    m_zero = (op == 8) ? ((m_res == 0) && (m_hi == 0)) : (m_res == 0);
  endfunction

  task automatic check_output(string tag, longint obs, longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag);
    check_output({tag, "_result"}, 64'(bus.RESULT), m_res);
    check_output({tag, "_hi"},     64'(bus.RESULT_HI), m_hi);
    check_output({tag, "_carry"},  64'(bus.carry_out), 64'(m_carry));
    check_output({tag, "_zero"},   64'(bus.ZERO), 64'(m_zero));
    check_output({tag, "_ovf"},    64'(bus.OVERFLOW), 64'(m_ovf));
    check_output({tag, "_ill"},    64'(bus.ILLEGAL), 64'(m_ill));
    check_output({tag, "_busy"},   64'(bus.BUSY), 64'(m_busy));
    check_output({tag, "_done"},   64'(bus.DONE), 64'(m_done));
  endtask

  // Issue one request and follow it to completion. Entered and left #1
  // after a rising edge, so calls chain back-to-back.
  task automatic apply_stimulus(string tag, int op, longint a, longint b, bit cin);
    bus.ALUOP    = 4'(op);
    bus.DATA_A   = WIDTH'(a);
    bus.DATA_B   = WIDTH'(b);
    bus.carry_in = cin;
    bus.START    = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    if (op == 8) begin
      check_output({tag, "_busy_start"}, 64'(bus.BUSY), 1);
      check_output({tag, "_done_start"}, 64'(bus.DONE), 0);
      for (int i = 1; i < WIDTH; i++) begin
        bus.DATA_A   = WIDTH'($urandom);
        bus.DATA_B   = WIDTH'($urandom);
        bus.ALUOP    = 4'($urandom);
        bus.carry_in = 1'($urandom);
        bus.START    = (i == 2);
        @(posedge CLK); #1;
        check_output($sformatf("%s_busy_c%0d", tag, i), 64'(bus.BUSY), 1);
        check_output($sformatf("%s_done_c%0d", tag, i), 64'(bus.DONE), 0);
      end
      bus.START = 1'b0;
      @(posedge CLK); #1;
    end
    model_apply(op, a, b, cin);
    check_state(tag);
    m_done = 0;
  endtask

  task automatic idle_cycle(string tag);
    bus.START = 1'b0;
    @(posedge CLK); #1;
    check_output({tag, "_done_low"}, 64'(bus.DONE), 0);
    check_output({tag, "_result_hold"}, 64'(bus.RESULT), m_res);
  endtask

  task automatic do_reset(string tag);
    RST = 1'b1;
    bus.START = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    check_state(tag);
  endtask

  initial begin
    int op;
    RST = 1'b1;
    bus.START = 1'b0; bus.ALUOP = '0; bus.DATA_A = '0; bus.DATA_B = '0; bus.carry_in = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    do_reset("reset");

    // 1: ADD with carry out
    apply_stimulus("t1_add", 2, 'hF0, 'h20, 0);
    check_output("t1_lit_result", 64'(bus.RESULT), 'h10);
    check_output("t1_lit_carry",  64'(bus.carry_out), 1);
    idle_cycle("t1");

    // 2: back-to-back SUB then ADDC
    apply_stimulus("t2_sub", 3, 'h05, 'h07, 0);
    check_output("t2_lit_sub", 64'(bus.RESULT), 'hFE);
    check_output("t2_lit_sub_c", 64'(bus.carry_out), 0);
    apply_stimulus("t2_addc", 4, 'hFF, 'h00, 1);
    check_output("t2_lit_addc_z", 64'(bus.ZERO), 1);
    check_output("t2_lit_addc_c", 64'(bus.carry_out), 1);

    // 3: signed overflow, then AND keeps carry
    apply_stimulus("t3_add", 2, 'h7F, 'h01, 0);
    check_output("t3_lit_ovf", 64'(bus.OVERFLOW), 1);
    apply_stimulus("t3_and", 0, 'hAA, 'h55, 0);
    check_output("t3_lit_and_z", 64'(bus.ZERO), 1);
    idle_cycle("t3");

    // 4: multiplies
    apply_stimulus("t4_mul", 8, 'hFF, 'hFF, 0);
    check_output("t4_lit_hi", 64'(bus.RESULT_HI), 'hFE);
    check_output("t4_lit_lo", 64'(bus.RESULT), 'h01);
    apply_stimulus("t4_mul0", 8, 'h00, 'h37, 0);
    check_output("t4_lit_zero", 64'(bus.ZERO), 1);

    // 5: reset aborts a multiply, and wins over a simultaneous START
    bus.ALUOP = 4'h8; bus.DATA_A = 8'h12; bus.DATA_B = 8'h34; bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1; bus.START = 1'b1; bus.ALUOP = 4'h2;
    @(posedge CLK); #1;
    RST = 1'b0; bus.START = 1'b0;
    model_reset();
    check_state("t5_abort");
    for (int i = 0; i < WIDTH + 2; i++) idle_cycle($sformatf("t5_nodone%0d", i));
    apply_stimulus("t5_cmp", 6, 'h03, 'h09, 0);
    check_output("t5_lit_cmp", 64'(bus.RESULT), 'h01);

    // 6: illegal opcode holds results, next legal op clears ILLEGAL
    apply_stimulus("t6_add", 2, 'h12, 'h34, 0);
    apply_stimulus("t6_ill", 15, 'h99, 'h11, 1);
    check_output("t6_lit_ill", 64'(bus.ILLEGAL), 1);
    check_output("t6_lit_hold", 64'(bus.RESULT), 'h46);
    apply_stimulus("t6_or", 1, 'h0F, 'hF0, 0);
    check_output("t6_lit_clr", 64'(bus.ILLEGAL), 0);

    // Random requests, with MUL weighted up and occasional idle gaps
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 15));
      apply_stimulus($sformatf("rnd%0d_op%0d", n, op), op,
                     longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
                     1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Width-parametrised, clocked successor of the datapath's 8-bit combinational ALU.
- Operands and opcode are latched on a START/DONE handshake; registered results and flags are held until the next completion.
- Single-cycle ops complete in 1 cycle. MUL runs as an iterative shift-add over WIDTH cycles and returns the full 2*WIDTH product.
- Sits between the register file and the writeback stage; the control FSM stalls on BUSY.

Parameters:
- WIDTH, 8: operand/result width in bits (legal range 4..32).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- ALUOP  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 ADDC, 0101 SUBC, 0110 CMP (unsigned A<B), 0111 XOR, 1000 MUL; all others illegal.
- DATA_A  in  WIDTH  operand A.
- DATA_B  in  WIDTH  operand B.
- carry_in  in  1  carry/not-borrow input for ADDC/SUBC.
- RESULT  out  WIDTH  result; low half for MUL.
- RESULT_HI  out  WIDTH  MUL high half; 0 for every other op.
- carry_out  out  1  carry / not-borrow flag.
- ZERO  out  1  result-zero flag.
- OVERFLOW  out  1  two's-complement overflow flag.
- ILLEGAL  out  1  last completed request had an undefined opcode.
- BUSY  out  1  MUL in progress.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset values:
  - RESULT=0, RESULT_HI=0, carry_out=0, ZERO=1, OVERFLOW=0, ILLEGAL=0, BUSY=0, DONE=0.
  - State=IDLE, multiplier counter=0.
  - RST mid-MUL aborts the operation with no DONE; RST wins over a simultaneous START.
- States: IDLE, MUL_RUN.
- IDLE, START=1, single-cycle op (sampled at edge k):
  - Results and flags are registered at edge k; DONE=1 during cycle k+1.
  - State stays IDLE, so a START every cycle gives one DONE per cycle.
- IDLE, START=1, MUL:
  - Latch A, B; clear the 2*WIDTH accumulator; count=0; BUSY=1 from edge k.
  - One multiplier bit per cycle (LSB first).
  - At edge k+WIDTH: outputs registered, DONE=1, BUSY=0, return to IDLE.
  - New START is accepted in the cycle DONE is high.
- MUL_RUN: START is ignored, not queued. Input changes after the START edge have no effect.
- Outputs update only on a completion edge and otherwise hold. DONE is low in every other cycle.
- Arithmetic uses WIDTH+1 internal sums; RESULT takes the low WIDTH bits:
  - ADD: carry_out=bit WIDTH of A+B.
  - SUB: RESULT=A-B (mod 2^WIDTH); carry_out=1 iff A>=B (no borrow).
  - ADDC: A+B+carry_in; carry_out=bit WIDTH.
  - SUBC: A-B-(1-carry_in); carry_out=1 iff A >= B+(1-carry_in).
  - OVERFLOW is signed overflow for ADD/ADDC/SUB/SUBC and 0 for all other ops.
  - CMP: RESULT=1 if A<B unsigned, else 0.
  - AND/OR/XOR/CMP: carry_out holds its previous value, so multi-precision chains are preserved.
  - MUL: {RESULT_HI,RESULT}=A*B unsigned; carry_out=1 iff RESULT_HI!=0.
- ZERO: (RESULT==0) for non-MUL; ({RESULT_HI,RESULT}==0) for MUL.
- Illegal opcode:
  - Completes as a single-cycle op: DONE pulses, ILLEGAL=1.
  - RESULT, RESULT_HI and all flags hold.
  - ILLEGAL clears on the next legal completion.
- Wrap-around: the multiplier counter saturates at WIDTH-1 and never wraps into a second pass.

Test Plan (WIDTH=8):
1. Reset, then ADD A=0xF0 B=0x20 START 1 cycle -> next cycle DONE=1, RESULT=0x10, carry_out=1, ZERO=0, OVERFLOW=0; DONE low the cycle after.
2. Back-to-back SUB 0x05-0x07, then ADDC 0xFF+0x00 cin=1 on consecutive cycles:
   - first DONE: RESULT=0xFE, carry_out=0;
   - second DONE: RESULT=0x00, carry_out=1, ZERO=1.
3. ADD 0x7F+0x01 -> RESULT=0x80, OVERFLOW=1, carry_out=0. Then AND 0xAA&0x55 -> RESULT=0x00, ZERO=1, carry_out held at 0, OVERFLOW=0.
4. MUL A=0xFF B=0xFF:
   - BUSY=1 for 8 cycles; extra START at cycle 3 ignored; inputs toggled mid-run have no effect;
   - DONE at cycle 8 with RESULT_HI=0xFE, RESULT=0x01, carry_out=1, ZERO=0;
   - MUL 0x00*0x37 -> ZERO=1, carry_out=0.
5. Start MUL, assert RST at cycle 4 -> no DONE ever; all outputs at reset values next cycle; a following CMP 0x03<0x09 -> RESULT=0x01.
6. ALUOP=1111 after a completed ADD -> DONE pulse, ILLEGAL=1, RESULT/flags unchanged. Next legal OR -> ILLEGAL=0.
